// File: rtl/controle_venda.sv
// Vending-machine controller: coin credit, product sale, change return one coin at a time.
// Optional idle-refund timeout enabled by defining CONTROLE_VENDA_TIMEOUT_EN.
module controle_venda #(
  parameter int CREDITO_MAX    = 16,
  parameter int TIMEOUT_CICLOS = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] codigoProduto,
  input  logic       codigoValido,
  input  logic       cent25,
  input  logic       cent50,
  input  logic       real1,
  input  logic       cancelar,
  output logic       liberar,
  output logic [3:0] produtoSaida,
  output logic       troco25,
  output logic       moedaRejeitada,
  output logic       erro,
  output logic [4:0] credito,
  output logic       ocupado
);

  typedef enum logic [1:0] {OCIOSO, VENDA, TROCO, TROCO_ESPERA} estado_t;

  localparam logic [5:0] CRED_MAX6 = 6'(CREDITO_MAX);

  estado_t    estado_q, estado_d;
  logic [4:0] credito_q, credito_d;
  logic [3:0] codigo_q, codigo_d;
  logic       rej_q, rej_d;
  logic       erro_q, erro_d;

  logic       qualquer_moeda;
  logic       multiplas;
  logic [1:0] n_moedas;
  logic [2:0] valor;
  logic [5:0] soma;
  logic [4:0] preco;
  logic       codigo_ok;
  logic       tem_credito;

`ifdef CONTROLE_VENDA_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS + 1) : 1;
  localparam logic [TW-1:0] CNT_LIM = TW'(TIMEOUT_CICLOS - 1);
  logic [TW-1:0] cnt_q, cnt_d;
`endif

  // Only the highest-value coin of a simultaneous group is evaluated.
  assign n_moedas       = {1'b0, cent25} + {1'b0, cent50} + {1'b0, real1};
  assign qualquer_moeda = cent25 | cent50 | real1;
  assign multiplas      = n_moedas > 2'd1;
  assign valor          = real1 ? 3'd4 : (cent50 ? 3'd2 : (cent25 ? 3'd1 : 3'd0));
  assign soma           = {1'b0, credito_q} + {3'b000, valor};
  assign preco          = 5'd2 + {3'b000, codigoProduto[1:0]};
  assign codigo_ok      = codigoProduto < 4'd12;
  assign tem_credito    = credito_q >= preco;

  always_comb begin
    estado_d  = estado_q;
    credito_d = credito_q;
    codigo_d  = codigo_q;
    rej_d     = qualquer_moeda;
    erro_d    = 1'b0;
`ifdef CONTROLE_VENDA_TIMEOUT_EN
    cnt_d     = '0;
`endif
    case (estado_q)
      OCIOSO: begin
        if (cancelar) begin
          if (credito_q != 5'd0) estado_d = TROCO;
        end else if (codigoValido) begin
          if (!codigo_ok || !tem_credito) begin
            erro_d = 1'b1;
          end else begin
            estado_d  = VENDA;
            credito_d = credito_q - preco;
            codigo_d  = codigoProduto;
          end
        end else if (qualquer_moeda) begin
          if (soma <= CRED_MAX6) begin
            credito_d = soma[4:0];
            rej_d     = multiplas;
          end
        end
`ifdef CONTROLE_VENDA_TIMEOUT_EN
        else if (credito_q != 5'd0) begin
          if (cnt_q == CNT_LIM) estado_d = TROCO;
          else                  cnt_d    = cnt_q + 1'b1;
        end
`endif
      end
      VENDA:        estado_d = (credito_q != 5'd0) ? TROCO : OCIOSO;
      TROCO: begin
        credito_d = credito_q - 5'd1;
        estado_d  = TROCO_ESPERA;
      end
      TROCO_ESPERA: estado_d = (credito_q != 5'd0) ? TROCO : OCIOSO;
      default:      estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      credito_q <= '0;
      codigo_q  <= '0;
      rej_q     <= 1'b0;
      erro_q    <= 1'b0;
`ifdef CONTROLE_VENDA_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      estado_q  <= estado_d;
      credito_q <= credito_d;
      codigo_q  <= codigo_d;
      rej_q     <= rej_d;
      erro_q    <= erro_d;
`ifdef CONTROLE_VENDA_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign liberar        = (estado_q == VENDA);
  assign produtoSaida   = liberar ? codigo_q : 4'd0;
  assign troco25        = (estado_q == TROCO);
  assign ocupado        = (estado_q != OCIOSO);
  assign credito        = credito_q;
  assign moedaRejeitada = rej_q;
  assign erro           = erro_q;

endmodule

// File: tb/tb_controle_venda.sv
// Directed bench for controle_venda; expectations hand-computed from the price/coin tables.
// Define CONTROLE_VENDA_TIMEOUT_EN to exercise the idle-refund path with TIMEOUT_CICLOS=8.
module tb_controle_venda;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] codigoProduto;
  logic       codigoValido, cent25, cent50, real1, cancelar;
  logic       liberar, troco25, moedaRejeitada, erro, ocupado;
  logic [3:0] produtoSaida;
  logic [4:0] credito;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

`ifdef CONTROLE_VENDA_TIMEOUT_EN
  localparam int TOUT = 8;
`else
  localparam int TOUT = 1024;
`endif

  controle_venda #(.CREDITO_MAX(16), .TIMEOUT_CICLOS(TOUT)) dut (
    .clk(clk), .reset(reset),
    .codigoProduto(codigoProduto), .codigoValido(codigoValido),
    .cent25(cent25), .cent50(cent50), .real1(real1), .cancelar(cancelar),
    .liberar(liberar), .produtoSaida(produtoSaida), .troco25(troco25),
    .moedaRejeitada(moedaRejeitada), .erro(erro), .credito(credito), .ocupado(ocupado)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    codigoValido = 0; cent25 = 0; cent50 = 0; real1 = 0; cancelar = 0; codigoProduto = 0;
  endtask

  task automatic coin(input int v);
    cent25 = (v == 1); cent50 = (v == 2); real1 = (v == 4);
    tick();
    clr_in();
  endtask

  task automatic code(input logic [3:0] c);
    codigoProduto = c; codigoValido = 1;
    tick();
    clr_in();
  endtask

  // Runs until the machine returns to idle; counts change pulses and gaps other than 2 cycles.
  task automatic drain(input int maxc, output int n, output int bad_gap, output int n_lib);
    int last;
    bit started;
    n = 0; bad_gap = 0; n_lib = 0; last = 0; started = 0;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      if (liberar) n_lib++;
      if (troco25) begin
        if (n > 0 && (c - last) != 2) bad_gap++;
        n++; last = c;
      end
      if (ocupado) started = 1;
      else if (started) break;
    end
  endtask

  int n, gaps, nlib;

  initial begin
    clr_in();
    reset = 1;
    tick(); tick();
    reset = 0;
    check("rst_credito", credito, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_outs", {liberar, troco25, moedaRejeitada, erro}, 0);
    check("rst_produto", produtoSaida, 0);

    // Insufficient credit, then exact-price sale with no change
    coin(4);
    check("r1_credito", credito, 4);
    code(4'd3);
    check("p3_erro", erro, 1);
    check("p3_credito_kept", credito, 4);
    check("p3_idle", ocupado, 0);
    tick();
    check("erro_single", erro, 0);
    coin(1);
    check("c25_credito", credito, 5);
    code(4'd3);
    check("venda_liberar", liberar, 1);
    check("venda_produto", produtoSaida, 3);
    check("venda_credito", credito, 0);
    tick();
    check("venda_after_lib", liberar, 0);
    check("venda_after_prod", produtoSaida, 0);
    check("venda_no_troco", troco25, 0);
    check("venda_after_idle", ocupado, 0);

    // Sale with 6 units of change
    coin(4); coin(4);
    check("2r1_credito", credito, 8);
    code(4'd0);
    check("p0_liberar", liberar, 1);
    check("p0_credito", credito, 6);
    drain(40, n, gaps, nlib);
    check("p0_troco_n", n, 6);
    check("p0_troco_gap", gaps, 0);
    check("p0_credito_end", credito, 0);
    check("p0_idle", ocupado, 0);

    // Ceiling: 4 coins fit, the 5th is rejected; invalid code keeps credit
    coin(4); coin(4); coin(4); coin(4);
    check("max_credito", credito, 16);
    check("max_no_rej", moedaRejeitada, 0);
    coin(4);
    check("over_rej", moedaRejeitada, 1);
    check("over_credito", credito, 16);
    code(4'd13);
    check("p13_erro", erro, 1);
    check("p13_credito", credito, 16);
    cancelar = 1; tick(); clr_in();
    check("cancel16_troco", troco25, 1);
    drain(60, n, gaps, nlib);
    check("cancel16_rest", n, 15);
    check("cancel16_nolib", nlib, 0);
    check("cancel16_credito", credito, 0);

    // Cancel refund; coin during change is rejected
    coin(2);
    check("c50_credito", credito, 2);
    cancelar = 1; tick(); clr_in();
    check("cancel_troco1", troco25, 1);
    check("cancel_ocupado", ocupado, 1);
    check("cancel_nolib", liberar, 0);
    cent25 = 1; tick(); clr_in();
    check("troco_coin_rej", moedaRejeitada, 1);
    check("troco_coin_cred", credito, 1);
    check("espera_no_troco", troco25, 0);
    tick();
    check("cancel_troco2", troco25, 1);
    tick(); tick();
    check("cancel_end_cred", credito, 0);
    check("cancel_end_idle", ocupado, 0);
    cancelar = 1; tick(); clr_in();
    check("cancel_zero_idle", ocupado, 0);

    // Coin together with a code strobe: coin rejected, code still evaluated
    cent25 = 1; codigoProduto = 4'd3; codigoValido = 1; tick(); clr_in();
    check("coin_code_rej", moedaRejeitada, 1);
    check("coin_code_erro", erro, 1);
    check("coin_code_cred", credito, 0);

    // Code and cancel together: cancel wins, no error
    coin(4);
    codigoProduto = 4'd0; codigoValido = 1; cancelar = 1; tick(); clr_in();
    check("cc_troco", troco25, 1);
    check("cc_no_erro", erro, 0);
    check("cc_no_lib", liberar, 0);
    drain(20, n, gaps, nlib);
    check("cc_rest", n, 3);

    // Simultaneous coins: only real1 counted; reset aborts change
    cent25 = 1; cent50 = 1; real1 = 1; tick(); clr_in();
    check("multi_credito", credito, 4);
    check("multi_rej", moedaRejeitada, 1);
    tick();
    check("multi_rej_single", moedaRejeitada, 0);
    cancelar = 1; tick(); clr_in();
    check("pre_rst_troco", troco25, 1);
    reset = 1; tick(); reset = 0;
    check("rst_mid_outs", {liberar, troco25, moedaRejeitada, erro, ocupado}, 0);
    check("rst_mid_cred", credito, 0);
    tick(); tick();
    check("rst_mid_quiet", troco25, 0);

    // Idle credit: refunded after timeout if enabled, held otherwise
    coin(2);
`ifdef CONTROLE_VENDA_TIMEOUT_EN
    drain(40, n, gaps, nlib);
    check("tout_troco_n", n, 2);
    check("tout_credito", credito, 0);
`else
    for (int i = 0; i < 40; i++) tick();
    check("hold_credito", credito, 2);
    check("hold_idle", ocupado, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
